// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants, FSM state encoding and buffer entry type for the register
// file dump reader.
package regfile_dump_reader_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } dumpState_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dumpEntry_t;

endpackage

// File: rtl/regfile_dump_reader_dump_pair_buffer.sv
// Two-entry address/data buffer with shift-on-pop and register-file write snoop,
// so buffered values always track the latest write to their register.
module dump_pair_buffer
  import regfile_dump_reader_pkg::*;
(
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              load,
  input  dumpEntry_t        loadEntry0,
  input  dumpEntry_t        loadEntry1,
  input  logic              pop,
  input  logic              snoopEn,
  input  logic [ADDR_W-1:0] snoopAddr,
  input  logic [DATA_W-1:0] snoopData,
  output dumpEntry_t        head,
  output logic              drained
);

  dumpEntry_t entry0, entry1;
  dumpEntry_t nextEntry0, nextEntry1;

  // Snoop is applied to the post-load/post-pop contents: a write in the fetch
  // cycle is captured as the new value, and a popping head keeps its old value.
  always_comb begin
    nextEntry0 = entry0;
    nextEntry1 = entry1;
    if (load) begin
      nextEntry0 = loadEntry0;
      nextEntry1 = loadEntry1;
    end else if (pop) begin
      nextEntry0 = entry1;
      nextEntry1 = '0;
    end
    if (snoopEn && nextEntry0.valid && nextEntry0.addr == snoopAddr)
      nextEntry0.data = snoopData;
    if (snoopEn && nextEntry1.valid && nextEntry1.addr == snoopAddr)
      nextEntry1.data = snoopData;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      entry0 <= nextEntry0;
      entry1 <= nextEntry1;
    end
  end

  assign head    = entry0;
  assign drained = pop && !entry1.valid;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive (wrapping) register range through the register file read
// ports, two registers per fetch, and streams (address, value) beats out.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] RS,
  output logic [ADDR_W-1:0] RT,
  input  logic [DATA_W-1:0] ReadRS,
  input  logic [DATA_W-1:0] ReadRT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutAddr,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              Done,
  output dumpState_t        DbgState
);

  // Handshake: a beat transfers on a rising edge where OutValid && OutReady;
  // once raised, OutValid holds (with stable OutAddr) until that transfer.
  dumpState_t        state, nextState;
  logic [ADDR_W-1:0] ptr, ptrNext, rsHold, rtHold, span;
  logic [5:0]        remaining, take;
  logic              fetch, pop, drained;
  dumpEntry_t        loadEntry0, loadEntry1, head;

  assign fetch   = (state == FETCH);
  assign ptrNext = ptr + 5'd1;
  assign span    = LastReg - FirstReg;
  assign take    = (remaining >= 6'd2) ? 6'd2 : 6'd1;

  assign RS = fetch ? ptr : rsHold;
  assign RT = fetch ? ptrNext : rtHold;

  assign loadEntry0 = '{valid: 1'b1, addr: ptr, data: ReadRS};
  assign loadEntry1 = '{valid: (remaining >= 6'd2), addr: ptrNext, data: ReadRT};

  assign OutValid = head.valid;
  assign OutAddr  = head.addr;
  assign OutData  = head.data;
  assign pop      = OutValid && OutReady;

  dump_pair_buffer u_buffer (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .load       (fetch),
    .loadEntry0 (loadEntry0),
    .loadEntry1 (loadEntry1),
    .pop        (pop),
    .snoopEn    (RegWrite),
    .snoopAddr  (RD),
    .snoopData  (WriteData),
    .head       (head),
    .drained    (drained)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (Start) nextState = FETCH;
      FETCH:   nextState = DRAIN;
      DRAIN:   if (drained) nextState = (remaining != 6'd0) ? FETCH : FINISH;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      rsHold    <= '0;
      rtHold    <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && Start) begin
        ptr       <= FirstReg;
        remaining <= {1'b0, span} + 6'd1;
      end
      if (fetch) begin
        ptr       <= ptr + 5'd2;
        remaining <= remaining - take;
        rsHold    <= ptr;
        rtHold    <= ptrNext;
      end
    end
  end

  assign Busy     = (state == FETCH) || (state == DRAIN);
  assign Done     = (state == FINISH);
  assign DbgState = state;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: a shadow register file plus an expected beat queue that
// follows register writes; a negedge monitor checks every beat and Done.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic              Clock = 1'b0;
  logic              ResetN, Start, RegWrite, OutReady;
  logic [ADDR_W-1:0] FirstReg, LastReg, RD;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] RS, RT, OutAddr;
  logic [DATA_W-1:0] ReadRS, ReadRT, OutData;
  logic              OutValid, Busy, Done;
  dumpState_t        DbgState;

  logic [DATA_W-1:0] regs [32];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  int fetchCnt = 0;
  bit doneSeen = 0;
  bit expectDone = 0;
  bit prevStall = 0;
  bit prevWr = 0;
  logic [ADDR_W-1:0] prevAddr, prevRd;
  logic [DATA_W-1:0] prevData, prevWd;

  regfile_dump_reader dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .FirstReg(FirstReg), .LastReg(LastReg),
    .RS(RS), .RT(RT), .ReadRS(ReadRS), .ReadRT(ReadRT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .OutValid(OutValid), .OutReady(OutReady), .OutAddr(OutAddr),
    .OutData(OutData), .Busy(Busy), .Done(Done), .DbgState(DbgState)
  );

  // clock / register file model
  always #5 Clock = ~Clock;
  assign ReadRS = regs[RS];
  assign ReadRT = regs[RT];
  always @(posedge Clock) if (RegWrite) regs[RD] <= WriteData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge Clock) begin
    if (!ResetN) begin
      prevStall  = 0;
      expectDone = 0;
    end else begin
      if (DbgState == FETCH) fetchCnt++;
      if (prevStall) begin
        check("stall_valid", {31'd0, OutValid}, 32'd1);
        check("stall_addr", {27'd0, OutAddr}, {27'd0, prevAddr});
        check("stall_data", {16'd0, OutData},
              {16'd0, (prevWr && prevRd == prevAddr) ? prevWd : prevData});
      end
      check("done", {31'd0, Done}, {31'd0, expectDone});
      if (Done) doneSeen = 1;
      expectDone = 0;
      if (OutValid && OutReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %0d data %0h expected no beat", OutAddr, OutData);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          check("beat_addr", {27'd0, OutAddr}, {27'd0, e[ADDR_W+DATA_W-1:DATA_W]});
          check("beat_data", {16'd0, OutData}, {16'd0, e[DATA_W-1:0]});
          if (exp_q.size() == 0) expectDone = 1;
        end
      end
      if (RegWrite)
        foreach (exp_q[i])
          if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == RD) exp_q[i][DATA_W-1:0] = WriteData;
      prevStall = OutValid && !OutReady;
      prevAddr  = OutAddr;
      prevData  = OutData;
      prevWr    = RegWrite;
      prevRd    = RD;
      prevWd    = WriteData;
    end
  end

  // driver tasks
  task automatic write_reg(input int r, input logic [DATA_W-1:0] v);
    @(posedge Clock); #1;
    RegWrite = 1; RD = ADDR_W'(r); WriteData = v;
    @(posedge Clock); #1;
    RegWrite = 0;
  endtask

  task automatic issue_dump(input int first, input int last, input bit fetchWr,
                            input int wrReg, input logic [DATA_W-1:0] wrVal);
    int n;
    logic [ADDR_W-1:0] a;
    n = ((last - first) & 31) + 1;
    @(posedge Clock); #1;
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'((first + i) & 31);
      exp_q.push_back({a, regs[a]});
    end
    doneSeen = 0;
    Start = 1; FirstReg = ADDR_W'(first); LastReg = ADDR_W'(last);
    @(posedge Clock); #1;
    Start = 0;
    fetchCnt = 0;
    if (fetchWr) begin
      RegWrite = 1; RD = ADDR_W'(wrReg); WriteData = wrVal;
    end
    @(negedge Clock);
    check("fetch_state", {31'd0, DbgState == FETCH}, 32'd1);
    check("fetch_busy", {31'd0, Busy}, 32'd1);
    check("fetch_valid", {31'd0, OutValid}, 32'd0);
    @(posedge Clock); #1;
    RegWrite = 0;
    @(negedge Clock);
    check("first_valid", {31'd0, OutValid}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !doneSeen; i++) @(negedge Clock);
    check("dump_done", {31'd0, doneSeen}, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);
    @(negedge Clock);
    check("idle_busy", {31'd0, Busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rs"}, {27'd0, RS}, 32'd0);
    check({tag, "_rt"}, {27'd0, RT}, 32'd0);
    check({tag, "_valid"}, {31'd0, OutValid}, 32'd0);
    check({tag, "_addr"}, {27'd0, OutAddr}, 32'd0);
    check({tag, "_data"}, {16'd0, OutData}, 32'd0);
    check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check({tag, "_done"}, {31'd0, Done}, 32'd0);
  endtask

  initial begin
    ResetN = 0; Start = 0; RegWrite = 0; OutReady = 1;
    FirstReg = '0; LastReg = '0; RD = '0; WriteData = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge Clock); #1;
    ResetN = 1;

    for (int r = 0; r < 32; r++) write_reg(r, DATA_W'($urandom_range(0, 16'hffff)));
    write_reg(3, 16'h000B);
    write_reg(8, 16'h000F);

    // range 3..8
    issue_dump(3, 8, 0, 0, '0);
    wait_done(100);
    check("fetches_3_8", fetchCnt, 32'd3);

    // wrapping range 30..1
    issue_dump(30, 1, 0, 0, '0);
    wait_done(100);
    check("fetches_30_1", fetchCnt, 32'd2);

    // single register
    issue_dump(5, 5, 0, 0, '0);
    wait_done(100);
    check("fetches_5_5", fetchCnt, 32'd1);

    // snoop while stalled on the head entry
    OutReady = 0;
    issue_dump(9, 10, 0, 0, '0);
    @(posedge Clock); #1;
    RegWrite = 1; RD = 5'd9; WriteData = 16'h1234;
    @(posedge Clock); #1;
    RegWrite = 0;
    repeat (2) @(posedge Clock);
    #1 OutReady = 1;
    wait_done(100);

    // write during the fetch cycle
    issue_dump(9, 9, 1, 9, 16'h5678);
    wait_done(100);

    // full dump with random back-pressure, writes and ignored Start pulses
    issue_dump(0, 31, 0, 0, '0);
    for (int i = 0; i < 2000 && !doneSeen; i++) begin
      @(posedge Clock); #1;
      OutReady  = 1'($urandom_range(0, 1));
      RegWrite  = ($urandom_range(0, 3) == 0);
      RD        = ADDR_W'($urandom_range(0, 31));
      WriteData = DATA_W'($urandom_range(0, 16'hffff));
      Start     = (exp_q.size() > 2) && ($urandom_range(0, 3) == 0);
      FirstReg  = ADDR_W'($urandom_range(0, 31));
      LastReg   = ADDR_W'($urandom_range(0, 31));
    end
    Start = 0; RegWrite = 0; OutReady = 1;
    wait_done(10);
    check("fetches_0_31", fetchCnt, 32'd16);

    // reset mid-drain, then a fresh dump
    OutReady = 0;
    issue_dump(0, 31, 0, 0, '0);
    repeat (2) @(posedge Clock);
    #3 ResetN = 0;
    #1;
    exp_q.delete();
    check_reset_outputs("midreset");
    repeat (2) begin
      @(negedge Clock);
      check("reset_hold_done", {31'd0, Done}, 32'd0);
      check("reset_hold_valid", {31'd0, OutValid}, 32'd0);
    end
    @(posedge Clock); #1;
    ResetN = 1; OutReady = 1;
    @(negedge Clock);
    check("post_reset_done", {31'd0, Done}, 32'd0);
    issue_dump(10, 13, 0, 0, '0);
    wait_done(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
